// File: rtl/wb_sram_bank_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// wb_sram_bank_ctrl_pkg
//
// Shared definitions for the Wishbone-to-banked-SRAM controller:
//   - default parameter values for the controller and its decoder
//   - the largest supported SRAM read latency and the width of the latency
//     counter derived from it
//   - the transaction FSM state encoding
//   - a helper that sizes the bank-index field (at least 1 bit, so a
//     single-bank build still has a legal vector to carry around)
// -----------------------------------------------------------------------------
package wb_sram_bank_ctrl_pkg;

    localparam int DEF_NUM_BANKS    = 2;
    localparam int DEF_SRAM_ADDR_WD = 8;
    localparam int DEF_SRAM_DATA_WD = 32;
    localparam int DEF_READ_LAT     = 1;

    localparam int MAX_BANKS        = 8;
    localparam int READ_LAT_MAX     = 3;

    // Counter spans 0..READ_LAT_MAX inclusive: one select cycle plus
    // READ_LAT wait cycles.
    localparam int LAT_CNT_WD       = $clog2(READ_LAT_MAX + 1);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WRITE     = 3'd1,
        ST_READ_WAIT = 3'd2,
        ST_ACK       = 3'd3,
        ST_ERR       = 3'd4
    } wb_state_e;

    // Width of a bank-index vector. The address field itself is
    // $clog2(num_banks) bits (zero for one bank); internal vectors are kept
    // at least one bit wide.
    function automatic int bank_idx_wd(input int num_banks);
        return (num_banks > 1) ? $clog2(num_banks) : 1;
    endfunction

endpackage : wb_sram_bank_ctrl_pkg

// File: rtl/wb_sram_bank_ctrl_bank_dec.sv
// -----------------------------------------------------------------------------
// wb_sram_bank_dec
//
// Turns a bank index plus an enable into an active-low one-hot chip-select
// vector. With en_i low, or with an index that names no existing bank, every
// select stays high.
//
// Ports:
//   bank_i  in   BANK_WD    bank index
//   en_i    in   1          access enable
//   csb_o   out  NUM_BANKS  active-low chip selects, bit k selects bank k
// -----------------------------------------------------------------------------
module wb_sram_bank_dec
    import wb_sram_bank_ctrl_pkg::*;
#(
    parameter int NUM_BANKS = DEF_NUM_BANKS,
    parameter int BANK_WD   = bank_idx_wd(NUM_BANKS)
) (
    input  logic [BANK_WD-1:0]   bank_i,
    input  logic                 en_i,
    output logic [NUM_BANKS-1:0] csb_o
);

    always_comb begin
        csb_o = '1;
        for (int k = 0; k < NUM_BANKS; k++) begin
            if (en_i && (bank_i == BANK_WD'(k))) begin
                csb_o[k] = 1'b0;
            end
        end
    end

endmodule : wb_sram_bank_dec

// File: rtl/wb_sram_bank_ctrl.sv
// -----------------------------------------------------------------------------
// wb_sram_bank_ctrl
//
// Wishbone classic slave in front of NUM_BANKS 1rw1r SRAM macros. Port A of
// each bank is used for reads, port B for writes. The byte address is split
// into a word address (shared by all banks) and a bank index; requests to a
// bank index that does not exist terminate with wb_err_o.
//
// Transfer timing, counting the cycle the request is presented as cycle 0:
//   write : cycle 1 drives port B, wb_ack_o in cycle 2
//   read  : cycle 1 selects port A, data captured READ_LAT cycles later,
//           wb_ack_o in cycle 2+READ_LAT
//   error : wb_err_o in cycle 1, no SRAM access
// The ACK/ERR cycle never samples a new request.
//
// Ports:
//   wb_clk_i     in   1             clock, all state on its rising edge
//   wb_rst_i     in   1             synchronous active-high reset
//   wb_cyc_i     in   1             bus cycle valid
//   wb_stb_i     in   1             strobe
//   wb_we_i      in   1             1 = write
//   wb_sel_i     in   DW/8          byte enables
//   wb_adr_i     in   32            byte address
//   wb_dat_i     in   DW            write data
//   wb_dat_o     out  DW            read data, held until the next read
//   wb_ack_o     out  1             normal termination
//   wb_err_o     out  1             error termination (bad bank)
//   sram_csb_a   out  NUM_BANKS     port-A chip selects, active low
//   sram_addr_a  out  AW            port-A word address
//   sram_dout_a  in   NUM_BANKS*DW  port-A read data, bank k at [k*DW +: DW]
//   sram_csb_b   out  NUM_BANKS     port-B chip selects, active low
//   sram_web_b   out  1             port-B write enable, active low
//   sram_mask_b  out  DW/8          port-B byte write mask
//   sram_addr_b  out  AW            port-B word address
//   sram_din_b   out  DW            port-B write data
// -----------------------------------------------------------------------------
module wb_sram_bank_ctrl
    import wb_sram_bank_ctrl_pkg::*;
#(
    parameter int NUM_BANKS    = DEF_NUM_BANKS,
    parameter int SRAM_ADDR_WD = DEF_SRAM_ADDR_WD,
    parameter int SRAM_DATA_WD = DEF_SRAM_DATA_WD,
    parameter int READ_LAT     = DEF_READ_LAT
) (
    input  logic                              wb_clk_i,
    input  logic                              wb_rst_i,
    input  logic                              wb_cyc_i,
    input  logic                              wb_stb_i,
    input  logic                              wb_we_i,
    input  logic [SRAM_DATA_WD/8-1:0]         wb_sel_i,
    input  logic [31:0]                       wb_adr_i,
    input  logic [SRAM_DATA_WD-1:0]           wb_dat_i,
    output logic [SRAM_DATA_WD-1:0]           wb_dat_o,
    output logic                              wb_ack_o,
    output logic                              wb_err_o,
    output logic [NUM_BANKS-1:0]              sram_csb_a,
    output logic [SRAM_ADDR_WD-1:0]           sram_addr_a,
    input  logic [NUM_BANKS*SRAM_DATA_WD-1:0] sram_dout_a,
    output logic [NUM_BANKS-1:0]              sram_csb_b,
    output logic                              sram_web_b,
    output logic [SRAM_DATA_WD/8-1:0]         sram_mask_b,
    output logic [SRAM_ADDR_WD-1:0]           sram_addr_b,
    output logic [SRAM_DATA_WD-1:0]           sram_din_b
);

    localparam int AW = SRAM_ADDR_WD;
    localparam int DW = SRAM_DATA_WD;
    localparam int SW = SRAM_DATA_WD / 8;
    localparam int BW = bank_idx_wd(NUM_BANKS);

    localparam logic [LAT_CNT_WD-1:0] LAT_LAST = LAT_CNT_WD'(READ_LAT);

    // -------------------------------------------------------------------------
    // State and registered request fields
    // -------------------------------------------------------------------------
    wb_state_e             state_q,  state_d;
    logic [LAT_CNT_WD-1:0] cnt_q,    cnt_d;
    logic [BW-1:0]         bank_q,   bank_d;
    logic [AW-1:0]         addr_q,   addr_d;
    logic [SW-1:0]         mask_q,   mask_d;
    logic [DW-1:0]         din_q,    din_d;
    logic [DW-1:0]         dat_q,    dat_d;

    // -------------------------------------------------------------------------
    // Address decode
    // -------------------------------------------------------------------------
    logic [AW-1:0] req_word;
    logic [BW-1:0] req_bank;
    logic          req_bank_ok;
    logic          req_valid;
    logic          unused_adr;

    assign req_word = wb_adr_i[AW+1:2];

    // The bank field only exists when there is more than one bank; address
    // bits above it are don't-care.
    if (NUM_BANKS > 1) begin : g_multi_bank
        assign req_bank   = wb_adr_i[AW+1+BW:AW+2];
        assign unused_adr = ^{wb_adr_i[31:AW+2+BW], wb_adr_i[1:0]};
    end else begin : g_single_bank
        assign req_bank   = '0;
        assign unused_adr = ^{wb_adr_i[31:AW+2], wb_adr_i[1:0]};
    end

    // Only reachable as false for non-power-of-two bank counts.
    assign req_bank_ok = ({{(32-BW){1'b0}}, req_bank} < 32'(NUM_BANKS));
    assign req_valid   = wb_cyc_i & wb_stb_i;

    // -------------------------------------------------------------------------
    // Read-data mux: pick the addressed bank's port-A output
    // -------------------------------------------------------------------------
    logic [DW-1:0] rd_slice;

    always_comb begin
        rd_slice = '0;
        for (int k = 0; k < NUM_BANKS; k++) begin
            if (bank_q == BW'(k)) begin
                rd_slice = sram_dout_a[k*DW +: DW];
            end
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bank_d  = bank_q;
        addr_d  = addr_q;
        mask_d  = mask_q;
        din_d   = din_q;
        dat_d   = dat_q;

        unique case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    if (!req_bank_ok) begin
                        state_d = ST_ERR;
                    end else begin
                        bank_d = req_bank;
                        addr_d = req_word;
                        cnt_d  = '0;
                        if (wb_we_i) begin
                            mask_d  = wb_sel_i;
                            din_d   = wb_dat_i;
                            state_d = ST_WRITE;
                        end else begin
                            state_d = ST_READ_WAIT;
                        end
                    end
                end
            end

            // The port-B access happens during this cycle regardless of
            // wb_cyc_i; dropping the cycle only suppresses the ack.
            ST_WRITE: begin
                state_d = wb_cyc_i ? ST_ACK : ST_IDLE;
            end

            // cnt_q == 0 is the select cycle; data for that select is valid
            // READ_LAT cycles later, which is when cnt_q reaches LAT_LAST.
            ST_READ_WAIT: begin
                if (!wb_cyc_i) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else if (cnt_q == LAT_LAST) begin
                    dat_d   = rd_slice;
                    cnt_d   = '0;
                    state_d = ST_ACK;
                end else begin
                    cnt_d = cnt_q + LAT_CNT_WD'(1);
                end
            end

            ST_ACK:  state_d = ST_IDLE;
            ST_ERR:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            bank_q  <= '0;
            addr_q  <= '0;
            mask_q  <= '0;
            din_q   <= '0;
            dat_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bank_q  <= bank_d;
            addr_q  <= addr_d;
            mask_q  <= mask_d;
            din_q   <= din_d;
            dat_q   <= dat_d;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs, decoded from state so reset or abort clears them on the
    // very next cycle
    // -------------------------------------------------------------------------
    logic sel_a_en;
    logic sel_b_en;

    assign sel_a_en = (state_q == ST_READ_WAIT) && (cnt_q == '0);
    // An all-zero byte mask still completes the bus cycle but touches no bank.
    assign sel_b_en = (state_q == ST_WRITE) && (|mask_q);

    wb_sram_bank_dec #(
        .NUM_BANKS (NUM_BANKS),
        .BANK_WD   (BW)
    ) u_dec_a (
        .bank_i (bank_q),
        .en_i   (sel_a_en),
        .csb_o  (sram_csb_a)
    );

    wb_sram_bank_dec #(
        .NUM_BANKS (NUM_BANKS),
        .BANK_WD   (BW)
    ) u_dec_b (
        .bank_i (bank_q),
        .en_i   (sel_b_en),
        .csb_o  (sram_csb_b)
    );

    assign sram_web_b  = (state_q != ST_WRITE);
    assign sram_addr_a = addr_q;
    assign sram_addr_b = addr_q;
    assign sram_mask_b = mask_q;
    assign sram_din_b  = din_q;

    assign wb_ack_o = (state_q == ST_ACK);
    assign wb_err_o = (state_q == ST_ERR);
    assign wb_dat_o = dat_q;

endmodule : wb_sram_bank_ctrl
